// File: rtl/wb_ic_pkg.sv
// ---------------------------------------------------------------------------
// wb_ic_pkg
//   Shared types for the Wishbone 1-to-N interconnect.
//   - state_t      : transaction FSM states (IDLE / ACTIVE / RESP)
//   - resp_kind_t  : kind of response returned to the master
//   - ERR_CNT_WIDTH: width of the saturating error statistics counter
//   - is_err()     : true for every response kind that is an error
//   - sat_inc()    : saturating increment for the error counter
// ---------------------------------------------------------------------------
package wb_ic_pkg;

    localparam int unsigned ERR_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        ACK,
        ERR_DECODE,
        ERR_TIMEOUT,
        ERR_SLAVE
    } resp_kind_t;

    function automatic logic is_err(input resp_kind_t kind);
        return kind != ACK;
    endfunction

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wb_interconnect_1ton_if.sv
// ---------------------------------------------------------------------------
// wb_interconnect_1ton_if
//   Bus bundle around the 1-to-N interconnect: the upstream master port
//   (wbm_*) and the broadcast / per-slave downstream ports (wbs_*).
//   Signal names are taken from the interconnect's point of view.
//   Modports:
//     slave  - the interconnect itself (a slave to the upstream master,
//              driving the downstream slave ports)
//     master - the surrounding system: upstream master plus peripherals
// ---------------------------------------------------------------------------
interface wb_interconnect_1ton_if #(
    parameter int unsigned NUM_SLAVES = 5,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

    // upstream master side
    logic [ADDR_WIDTH-1:0]            wbm_adr_i;
    logic [DATA_WIDTH-1:0]            wbm_dat_i;
    logic                             wbm_we_i;
    logic [SEL_WIDTH-1:0]             wbm_sel_i;
    logic                             wbm_stb_i;
    logic                             wbm_cyc_i;
    logic [DATA_WIDTH-1:0]            wbm_dat_o;
    logic                             wbm_ack_o;
    logic                             wbm_err_o;

    // downstream slave side
    logic [ADDR_WIDTH-1:0]            wbs_adr_o;
    logic [DATA_WIDTH-1:0]            wbs_dat_o;
    logic                             wbs_we_o;
    logic [SEL_WIDTH-1:0]             wbs_sel_o;
    logic [NUM_SLAVES-1:0]            wbs_cyc_o;
    logic [NUM_SLAVES-1:0]            wbs_stb_o;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i;
    logic [NUM_SLAVES-1:0]            wbs_ack_i;
    logic [NUM_SLAVES-1:0]            wbs_err_i;

    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o,
        output wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_cyc_o, wbs_stb_o,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i
    );

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o,
        input  wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_cyc_o, wbs_stb_o,
        output wbs_dat_i, wbs_ack_i, wbs_err_i
    );

endinterface

// File: rtl/wb_ic_addr_decoder.sv
// ---------------------------------------------------------------------------
// wb_ic_addr_decoder
//   Combinational base/mask address decoder. Slave i hits when
//   (adr & mask_i) == base_i. On overlapping windows the lowest index wins,
//   so hit_onehot always has at most one bit set.
//   Ports:
//     adr        in   address to decode
//     hit_onehot out  one-hot selected slave (all zero on a miss)
//     hit        out  any slave selected
// ---------------------------------------------------------------------------
module wb_ic_addr_decoder #(
    parameter int unsigned                       NUM_SLAVES = 5,
    parameter int unsigned                       ADDR_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
    input  logic [ADDR_WIDTH-1:0] adr,
    output logic [NUM_SLAVES-1:0] hit_onehot,
    output logic                  hit
);

    always_comb begin
        hit_onehot = '0;
        hit        = 1'b0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!hit &&
                ((adr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit_onehot[i] = 1'b1;
                hit           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_interconnect_1ton.sv
// ---------------------------------------------------------------------------
// wb_interconnect_1ton
//   Single-master, N-slave Wishbone classic interconnect with registered
//   strobes, a per-transaction timeout watchdog, decode-error responses and
//   saturating error statistics.
//   Ports:
//     i_clk          in   system clock
//     i_rst_n        in   asynchronous active-low reset
//     bus            if   master + per-slave Wishbone signals (slave modport)
//     o_err_count    out  saturating count of decode/timeout/slave errors
//     o_last_err_adr out  address of the most recent error
//     o_busy         out  transaction in flight (state != IDLE)
// ---------------------------------------------------------------------------
module wb_interconnect_1ton
    import wb_ic_pkg::*;
#(
    parameter int unsigned                       NUM_SLAVES     = 5,
    parameter int unsigned                       ADDR_WIDTH     = 32,
    parameter int unsigned                       DATA_WIDTH     = 32,
    parameter int unsigned                       SEL_WIDTH      = DATA_WIDTH / 8,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE     =
        {32'h500, 32'h400, 32'h300, 32'h200, 32'h000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK     =
        {32'hFFFFFF00, 32'hFFFFFFFC, 32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFFF00},
    parameter int unsigned                       TIMEOUT_CYCLES = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    wb_interconnect_1ton_if.slave    bus,
    output logic [ERR_CNT_WIDTH-1:0] o_err_count,
    output logic [ADDR_WIDTH-1:0]    o_last_err_adr,
    output logic                     o_busy
);

    localparam int unsigned TMO_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   state_q, state_d;
    logic [TMO_WIDTH-1:0]     tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0]    adr_q, adr_d;
    logic [DATA_WIDTH-1:0]    wdat_q, wdat_d;
    logic                     we_q, we_d;
    logic [SEL_WIDTH-1:0]     sel_q, sel_d;
    logic [NUM_SLAVES-1:0]    stb_q, stb_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [DATA_WIDTH-1:0]    rdat_q, rdat_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]    last_err_q, last_err_d;
    logic                     busy_q;

    logic [NUM_SLAVES-1:0]    dec_onehot;
    logic                     dec_hit;
    logic                     sel_ack;
    logic                     sel_err;
    logic [DATA_WIDTH-1:0]    sel_rdat;
    logic                     respond;
    resp_kind_t               resp_kind;
    logic [ADDR_WIDTH-1:0]    err_adr;

    // Decode on the live master address: the request is accepted in the same
    // cycle the fields are latched.
    wb_ic_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decoder (
        .adr        (bus.wbm_adr_i),
        .hit_onehot (dec_onehot),
        .hit        (dec_hit)
    );

    // The registered one-hot strobe doubles as the response-mux select, so
    // responses from unselected slaves never reach the FSM.
    assign sel_ack = |(bus.wbs_ack_i & stb_q);
    assign sel_err = |(bus.wbs_err_i & stb_q);

    always_comb begin
        sel_rdat = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (stb_q[i]) begin
                sel_rdat = sel_rdat | bus.wbs_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        we_d       = we_q;
        sel_d      = sel_q;
        stb_d      = stb_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdat_d     = rdat_q;
        err_cnt_d  = err_cnt_q;
        last_err_d = last_err_q;
        respond    = 1'b0;
        resp_kind  = ACK;
        err_adr    = adr_q;

        case (state_q)
            IDLE: begin
                stb_d = '0;
                if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
                    adr_d   = bus.wbm_adr_i;
                    wdat_d  = bus.wbm_dat_i;
                    we_d    = bus.wbm_we_i;
                    sel_d   = bus.wbm_sel_i;
                    err_adr = bus.wbm_adr_i;
                    if (dec_hit) begin
                        stb_d   = dec_onehot;
                        tmo_d   = '0;
                        state_d = ACTIVE;
                    end else begin
                        respond   = 1'b1;
                        resp_kind = ERR_DECODE;
                    end
                end
            end

            ACTIVE: begin
                // Priority: abort, slave err, slave ack, timeout.
                if (!bus.wbm_cyc_i) begin
                    stb_d   = '0;
                    state_d = IDLE;
                end else if (sel_err) begin
                    respond   = 1'b1;
                    resp_kind = ERR_SLAVE;
                end else if (sel_ack) begin
                    respond   = 1'b1;
                    resp_kind = ACK;
                end else if (tmo_q == TMO_LAST) begin
                    respond   = 1'b1;
                    resp_kind = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            RESP: begin
                stb_d   = '0;
                state_d = IDLE;
            end

            default: begin
                stb_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (respond) begin
            state_d = RESP;
            stb_d   = '0;
            if (is_err(resp_kind)) begin
                err_d      = 1'b1;
                rdat_d     = '0;
                err_cnt_d  = sat_inc(err_cnt_q);
                last_err_d = err_adr;
            end else begin
                ack_d  = 1'b1;
                rdat_d = sel_rdat;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            adr_q      <= '0;
            wdat_q     <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            stb_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdat_q     <= '0;
            err_cnt_q  <= '0;
            last_err_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            stb_q      <= stb_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdat_q     <= rdat_d;
            err_cnt_q  <= err_cnt_d;
            last_err_q <= last_err_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign bus.wbm_dat_o  = rdat_q;
    assign bus.wbm_ack_o  = ack_q;
    assign bus.wbm_err_o  = err_q;
    assign bus.wbs_adr_o  = adr_q;
    assign bus.wbs_dat_o  = wdat_q;
    assign bus.wbs_we_o   = we_q;
    assign bus.wbs_sel_o  = sel_q;
    assign bus.wbs_cyc_o  = stb_q;
    assign bus.wbs_stb_o  = stb_q;
    assign o_err_count    = err_cnt_q;
    assign o_last_err_adr = last_err_q;
    assign o_busy         = busy_q;

endmodule
